// File: rtl/io_macro_select_ctrl.sv
// io_macro_select_ctrl: break-before-make pad mux for N_CH user macros,
// selected by a Wishbone CTRL register or an LA override.
module io_macro_select_ctrl #(
   parameter int          N_CH      = 4,
   parameter int          IO_W      = 38,
   parameter int          GUARD_CYC = 8,
   parameter logic [31:0] BASE_ADDR = 32'h3000_0000
) (
   input  logic               wb_clk_i,
   input  logic               wb_rst_i,
   input  logic               wbs_stb_i,
   input  logic               wbs_cyc_i,
   input  logic               wbs_we_i,
   input  logic [3:0]         wbs_sel_i,
   input  logic [31:0]        wbs_dat_i,
   input  logic [31:0]        wbs_adr_i,
   output logic               wbs_ack_o,
   output logic [31:0]        wbs_dat_o,
   input  logic [N_CH-1:0]    la_active_i,
   input  logic [N_CH*IO_W-1:0] ch_io_out_i,
   input  logic [N_CH*IO_W-1:0] ch_io_oeb_i,
   output logic [IO_W-1:0]    io_out,
   output logic [IO_W-1:0]    io_oeb,
   output logic [N_CH-1:0]    ch_active_o,
   output logic               busy_o
);
   localparam int CW = (N_CH > 1) ? $clog2(N_CH) : 1;
   localparam int GW = (GUARD_CYC > 1) ? $clog2(GUARD_CYC) : 1;
   localparam logic [GW-1:0] GLOAD = GW'(GUARD_CYC - 1);

   typedef enum logic [1:0] {S_OFF, S_GUARD, S_ON} state_e;

   state_e          state_q, state_d;
   logic [CW-1:0]   tgt_q, tgt_d, cur_q, cur_d, la_idx, req;
   logic [GW-1:0]   cnt_q, cnt_d;
   logic [15:0]     swcnt_q, swcnt_d;
   logic [31:0]     ctrl_q, ctrl_d, dat_q, dat_d, status, rdata;
   logic            err_q, err_d, bad_q, ack_q, busy_q, busy_d;
   logic [N_CH-1:0] act_q, act_d;
   logic [IO_W-1:0] out_q, out_d, oeb_q, oeb_d;
   logic [3:0]      req_sel;
   logic [5:0]      off;
   logic            la_ovr, req_raw, req_bad, req_en;
   logic            hit, access, wr, rd, err_clr, drive;
   logic            unused_adr;

   assign unused_adr = ^wbs_adr_i[1:0];

   always_comb begin
      la_idx = '0;
      for (int i = N_CH - 1; i >= 0; i--) begin
         if (la_active_i[i]) la_idx = CW'(i);
      end
      la_ovr = |la_active_i;
      if (la_ovr) begin
         req_sel = 4'(la_idx);
         req_raw = 1'b1;
      end else begin
         req_sel = ctrl_q[3:0];
         req_raw = ctrl_q[31];
      end
      req_bad = req_raw && ({1'b0, req_sel} >= 5'(N_CH));
      req_en  = req_raw && !req_bad;
      req     = req_sel[CW-1:0];
   end

   assign off    = wbs_adr_i[7:2];
   assign hit    = wbs_adr_i[31:8] == BASE_ADDR[31:8];
   assign access = wbs_stb_i && wbs_cyc_i && !ack_q && hit;
   assign wr     = access && wbs_we_i;
   assign rd     = access && !wbs_we_i;
   assign err_clr = wr && (off == 6'd1) && wbs_dat_i[11];

   assign status = {swcnt_q, 4'b0, err_q, la_ovr,
                    state_q == S_GUARD, state_q == S_ON,
                    4'b0, 4'(cur_q)};

   always_comb begin
      ctrl_d = ctrl_q;
      if (wr && off == 6'd0) begin
         for (int b = 0; b < 4; b++) begin
            if (wbs_sel_i[b]) ctrl_d[8*b +: 8] = wbs_dat_i[8*b +: 8];
         end
      end
      if (off == 6'd0)      rdata = ctrl_q;
      else if (off == 6'd1) rdata = status;
      else                  rdata = '0;
      dat_d = rd ? rdata : '0;
      // ERR latches on the onset of a bad request so software can clear it
      err_d = (err_q && !err_clr) || (req_bad && !bad_q);
   end

   always_comb begin
      state_d = state_q;
      tgt_d   = tgt_q;
      cnt_d   = cnt_q;
      cur_d   = cur_q;
      swcnt_d = swcnt_q;
      unique case (state_q)
         S_OFF: begin
            if (req_en) begin
               state_d = S_GUARD;
               tgt_d   = req;
               cnt_d   = GLOAD;
            end
         end
         S_GUARD: begin
            if (!req_en) begin
               state_d = S_OFF;
            end else if (req != tgt_q) begin
               tgt_d = req;
               cnt_d = GLOAD;
            end else if (cnt_q == '0) begin
               state_d = S_ON;
               cur_d   = tgt_q;
               if (swcnt_q != 16'hFFFF) swcnt_d = swcnt_q + 16'd1;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         S_ON: begin
            if (!req_en) begin
               state_d = S_OFF;
            end else if (req != cur_q) begin
               state_d = S_GUARD;
               tgt_d   = req;
               cnt_d   = GLOAD;
            end
         end
         default: state_d = S_OFF;
      endcase

      act_d  = (state_d == S_ON) ? (N_CH'(1) << cur_d) : '0;
      busy_d = state_d == S_GUARD;
      // pads follow one cycle behind ch_active_o on entry, drop with it on exit
      drive  = (state_q == S_ON) && (state_d == S_ON);
      out_d  = drive ? ch_io_out_i[int'(cur_q)*IO_W +: IO_W] : '0;
      oeb_d  = drive ? ch_io_oeb_i[int'(cur_q)*IO_W +: IO_W] : '1;
   end

   always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
      if (wb_rst_i) begin
         state_q <= S_OFF;
         tgt_q   <= '0;
         cnt_q   <= '0;
         cur_q   <= '0;
         swcnt_q <= '0;
         ctrl_q  <= '0;
         err_q   <= 1'b0;
         bad_q   <= 1'b0;
         ack_q   <= 1'b0;
         dat_q   <= '0;
         act_q   <= '0;
         busy_q  <= 1'b0;
         out_q   <= '0;
         oeb_q   <= '1;
      end else begin
         state_q <= state_d;
         tgt_q   <= tgt_d;
         cnt_q   <= cnt_d;
         cur_q   <= cur_d;
         swcnt_q <= swcnt_d;
         ctrl_q  <= ctrl_d;
         err_q   <= err_d;
         bad_q   <= req_bad;
         ack_q   <= access;
         dat_q   <= dat_d;
         act_q   <= act_d;
         busy_q  <= busy_d;
         out_q   <= out_d;
         oeb_q   <= oeb_d;
      end
   end

   assign wbs_ack_o   = ack_q;
   assign wbs_dat_o   = dat_q;
   assign ch_active_o = act_q;
   assign busy_o      = busy_q;
   assign io_out      = out_q;
   assign io_oeb      = oeb_q;

endmodule

// File: tb/tb_io_macro_select_ctrl.sv
// tb_io_macro_select_ctrl: directed scenarios plus random LA/WB traffic
// against a cycle-level behavioural model of the pad selector.
module tb_io_macro_select_ctrl;
   localparam int N = 4;
   localparam int W = 38;
   localparam int G = 8;
   localparam logic [31:0] BASE = 32'h3000_0000;
   localparam int MOFF = 0, MGRD = 1, MON = 2;
   localparam logic [63:0] ONES = 64'h3F_FFFF_FFFF;

   logic clk = 0, rst = 0;
   logic stb = 0, cyc = 0, we = 0;
   logic [3:0] sel = 0;
   logic [31:0] wdat = 0, adr = 0;
   logic ack;
   logic [31:0] rdat;
   logic [N-1:0] la = 0;
   logic [N*W-1:0] chout = '0, choeb = '1;
   logic [W-1:0] io_out, io_oeb;
   logic [N-1:0] act;
   logic busy;

   int checks = 0, errors = 0;

   int m_mode = MOFF, m_left = 0, m_tgt = 0, m_cur = 0;
   logic [31:0] m_ctrl = 0;
   logic m_err = 0, m_badp = 0;
   logic [15:0] m_sw = 0;
   logic [N-1:0] e_act = 0;
   logic e_busy = 0, e_ack = 0;
   logic [W-1:0] e_out = 0, e_oeb = '1;
   logic [31:0] e_dat = 0;

   io_macro_select_ctrl #(.N_CH(N), .IO_W(W), .GUARD_CYC(G),
                          .BASE_ADDR(BASE)) dut (
      .wb_clk_i(clk), .wb_rst_i(rst),
      .wbs_stb_i(stb), .wbs_cyc_i(cyc), .wbs_we_i(we),
      .wbs_sel_i(sel), .wbs_dat_i(wdat), .wbs_adr_i(adr),
      .wbs_ack_o(ack), .wbs_dat_o(rdat),
      .la_active_i(la), .ch_io_out_i(chout), .ch_io_oeb_i(choeb),
      .io_out(io_out), .io_oeb(io_oeb),
      .ch_active_o(act), .busy_o(busy));

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [63:0] a,
                      input logic [63:0] e);
      checks++;
      if (a !== e) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", nm, a, e);
      end
   endtask

   task automatic model_step();
      int req, pm;
      logic en, bad, ovr, acc, clr;
      logic [31:0] st;
      if (rst) begin
         m_mode = MOFF; m_left = 0; m_tgt = 0; m_cur = 0;
         m_ctrl = 0; m_err = 0; m_badp = 0; m_sw = 0;
         e_act = 0; e_busy = 0; e_ack = 0;
         e_out = 0; e_oeb = '1; e_dat = 0;
         return;
      end
      ovr = la != 0;
      bad = 0;
      req = 0;
      if (ovr) begin
         for (int k = N - 1; k >= 0; k--) if (la[k]) req = k;
         en = 1;
      end else begin
         req = int'(m_ctrl[3:0]);
         en = m_ctrl[31];
         if (en && req >= N) begin bad = 1; en = 0; end
      end
      st = {m_sw, 4'b0, m_err, ovr, m_mode == MGRD, m_mode == MON,
            4'b0, 4'(m_cur)};
      acc = stb && cyc && !e_ack && adr[31:8] == BASE[31:8];
      clr = acc && we && adr[7:2] == 1 && wdat[11];
      e_dat = 0;
      if (acc && !we)
         e_dat = (adr[7:2] == 0) ? m_ctrl : (adr[7:2] == 1) ? st : 0;
      if (acc && we && adr[7:2] == 0)
         for (int b = 0; b < 4; b++)
            if (sel[b]) m_ctrl[8*b +: 8] = wdat[8*b +: 8];
      e_ack = acc;
      m_err = (m_err && !clr) || (bad && !m_badp);
      m_badp = bad;
      pm = m_mode;
      if (m_mode == MOFF) begin
         if (en) begin m_mode = MGRD; m_tgt = req; m_left = G; end
      end else if (m_mode == MGRD) begin
         if (!en) m_mode = MOFF;
         else if (req != m_tgt) begin m_tgt = req; m_left = G; end
         else if (m_left == 1) begin
            m_mode = MON; m_cur = m_tgt;
            if (m_sw != 16'hFFFF) m_sw = m_sw + 1;
         end else m_left--;
      end else begin
         if (!en) m_mode = MOFF;
         else if (req != m_cur) begin
            m_mode = MGRD; m_tgt = req; m_left = G;
         end
      end
      e_act = '0;
      if (m_mode == MON) e_act[m_cur] = 1'b1;
      e_busy = m_mode == MGRD;
      if (pm == MON && m_mode == MON) begin
         e_out = chout[m_cur*W +: W];
         e_oeb = choeb[m_cur*W +: W];
      end else begin
         e_out = 0;
         e_oeb = '1;
      end
   endtask

   initial forever begin
      @(posedge clk or posedge rst);
      model_step();
   end

   initial begin
      #2;
      forever begin
         @(negedge clk);
         chk("act", 64'(act), 64'(e_act));
         chk("busy", 64'(busy), 64'(e_busy));
         chk("io_out", 64'(io_out), 64'(e_out));
         chk("io_oeb", 64'(io_oeb), 64'(e_oeb));
         chk("ack", 64'(ack), 64'(e_ack));
         chk("rdat", 64'(rdat), 64'(e_dat));
      end
   end

   task automatic wb(input logic w, input logic [31:0] a,
                     input logic [31:0] d, input logic [3:0] s,
                     output logic [31:0] r);
      @(negedge clk); #1;
      stb = 1; cyc = 1; we = w; adr = a; wdat = d; sel = s;
      @(negedge clk);
      chk("wb_ack_rise", 64'(ack), 64'd1);
      r = rdat;
      #1 stb = 0; cyc = 0; we = 0;
      @(negedge clk);
      chk("wb_ack_fall", 64'(ack), 64'd0);
   endtask

   task automatic wait_guard(output int n);
      int t;
      n = 0;
      t = 0;
      while (!busy && t < 20) begin @(negedge clk); t++; end
      while (busy && n < 100) begin n++; @(negedge clk); end
   endtask

   logic [31:0] r;
   int n;

   initial begin
      #1 rst = 1;
      repeat (3) @(negedge clk);
      chk("rst_act", 64'(act), 64'd0);
      chk("rst_oeb", 64'(io_oeb), ONES);
      chk("rst_out", 64'(io_out), 64'd0);
      chk("rst_busy", 64'(busy), 64'd0);
      #1 rst = 0;
      wb(0, BASE + 4, 0, 4'hF, r);
      chk("status_rst", 64'(r), 64'h0);

      for (int k = 0; k < N; k++) begin
         chout[k*W +: W] = W'(k * 1000 + 77);
         choeb[k*W +: W] = ~W'(k);
      end
      wb(1, BASE, 32'h8000_0002, 4'hF, r);
      wait_guard(n);
      chk("guard_len_ch2", 64'(n), 64'd8);
      chk("act_ch2", 64'(act), 64'b0100);
      chk("oeb_first_on", 64'(io_oeb), ONES);
      @(negedge clk);
      chk("out_ch2", 64'(io_out), 64'd2077);
      chk("oeb_ch2", 64'(io_oeb), 64'h3F_FFFF_FFFD);
      wb(0, BASE + 4, 0, 4'hF, r);
      chk("status_ch2", 64'(r), 64'h0001_0102);

      wb(1, BASE, 32'h8000_0001, 4'hF, r);
      wait_guard(n);
      chk("guard_len_ch1", 64'(n), 64'd8);
      chk("act_ch1", 64'(act), 64'b0010);
      wb(0, BASE + 4, 0, 4'hF, r);
      chk("status_ch1", 64'(r), 64'h0002_0101);

      #1 la = 4'b1010;
      repeat (4) @(negedge clk);
      chk("la_same_busy", 64'(busy), 64'd0);
      chk("la_same_act", 64'(act), 64'b0010);
      #1 la = 4'b1000;
      wait_guard(n);
      chk("guard_len_la3", 64'(n), 64'd8);
      chk("act_la3", 64'(act), 64'b1000);
      wb(0, BASE + 4, 0, 4'hF, r);
      chk("status_la3", 64'(r), 64'h0003_0503);

      #1 la = 0;
      wb(1, BASE, 32'h8000_0009, 4'hF, r);
      repeat (3) @(negedge clk);
      chk("err_act", 64'(act), 64'd0);
      wb(0, BASE + 4, 0, 4'hF, r);
      chk("status_err", 64'(r), 64'h0003_0803);
      wb(1, BASE + 4, 32'h0000_0800, 4'hF, r);
      wb(0, BASE + 4, 0, 4'hF, r);
      chk("status_errclr", 64'(r), 64'h0003_0003);

      wb(1, BASE, 32'h8000_0000, 4'hF, r);
      n = 0;
      while (!busy && n < 20) begin @(negedge clk); n++; end
      chk("busy_before_rst", 64'(busy), 64'd1);
      repeat (3) @(negedge clk);
      #2 rst = 1;
      #1;
      chk("arst_act", 64'(act), 64'd0);
      chk("arst_busy", 64'(busy), 64'd0);
      chk("arst_oeb", 64'(io_oeb), ONES);
      chk("arst_out", 64'(io_out), 64'd0);
      repeat (2) @(negedge clk);
      #1 rst = 0;
      repeat (6) @(negedge clk);
      chk("post_rst_busy", 64'(busy), 64'd0);
      chk("post_rst_act", 64'(act), 64'd0);
      wb(0, BASE, 0, 4'hF, r);
      chk("post_rst_ctrl", 64'(r), 64'd0);

      for (int c = 0; c < 3000; c++) begin
         @(negedge clk); #1;
         for (int k = 0; k < N; k++) begin
            chout[k*W +: W] = W'({$urandom, $urandom});
            choeb[k*W +: W] = W'({$urandom, $urandom});
         end
         if (stb) begin
            stb = 0; cyc = 0; we = 0;
         end else if ($urandom_range(0, 9) == 0) begin
            int op;
            op = $urandom_range(0, 9);
            stb = 1; cyc = 1;
            sel = $urandom_range(0, 1) ? 4'hF : 4'($urandom);
            wdat = $urandom;
            adr = BASE;
            we = 1;
            if (op <= 4) begin
               wdat[31] = 1'($urandom_range(0, 3) != 0);
               wdat[3:0] = 4'($urandom_range(0, 5));
            end else if (op == 5) adr = BASE + 4;
            else if (op <= 7) begin
               we = 0;
               adr = BASE + 4 * $urandom_range(0, 3);
            end else if (op == 8) begin
               we = 1'($urandom);
               adr = BASE + 32'h100;
            end else adr = BASE + 8;
         end
         if ($urandom_range(0, 24) == 0)
            la = $urandom_range(0, 1) ? '0 : N'($urandom);
      end
      stb = 0; cyc = 0; we = 0; la = 0;
      repeat (3) @(negedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
